// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine arbiter.
// State encoding, datapath width, default requester count and watchdog limit.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam int GCD_W       = 16;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// searching cyclically; returns one-hot grant and its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int   w_j;
  logic w_hit;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    w_hit   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      w_hit = |(i_req & (N'(1) << w_j));
      if (w_hit) begin
        o_grant = N'(1) << w_j;
        o_idx   = PW'(w_j);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD engine among NREQ requesters.
// Define GCD_ARB_TIMEOUT_EN to add the WAIT watchdog and resp_err output.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = GCD_W
`ifdef GCD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] resp_valid,
  output logic [W-1:0]    resp_data,
  output logic            busy,
  output logic            gcd_start,
  output logic [W-1:0]    gcd_data_in,
  input  logic            gcd_done,
  input  logic [W-1:0]    gcd_result
`ifdef GCD_ARB_TIMEOUT_EN
  ,
  output logic            resp_err
`endif
);

  localparam int PW = $clog2(NREQ);

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [W-1:0]    w_a_in;
  logic [W-1:0]    w_b_in;
  logic            w_zero;
  logic            w_take;
  logic            w_tmo;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_a_in = req_a[w_idx*W +: W];
  assign w_b_in = req_b[w_idx*W +: W];
  assign w_zero = (w_a_in == '0) || (w_b_in == '0);
  assign w_take = (r_state == IDLE) && w_any;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = w_zero ? RESP : START;
      START:   w_next = LOAD_A;
      LOAD_A:  w_next = LOAD_B;
      LOAD_B:  w_next = WAIT;
      WAIT:    if (gcd_done || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    gcd_data_in = '0;
    unique case (1'b1)
      (r_state == START),
      (r_state == LOAD_A): gcd_data_in = r_a;
      (r_state == LOAD_B),
      (r_state == WAIT):   gcd_data_in = r_b;
      default:             gcd_data_in = '0;
    endcase
  end

  assign busy       = (r_state != IDLE);
  assign gcd_start  = (r_state == START);
  assign req_ready  = (w_take && !rst) ? w_grant : '0;
  assign resp_valid = (r_state == RESP) ? (NREQ'(1) << r_owner) : '0;
  assign resp_data  = r_result;

  // r_result only moves on the way into RESP, so it holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_a     <= w_a_in;
        r_b     <= w_b_in;
        r_owner <= w_idx;
        r_ptr   <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        if (w_zero) r_result <= w_a_in | w_b_in;
      end
      if (r_state == WAIT) begin
        if (gcd_done) r_result <= gcd_result;
        else if (w_tmo) r_result <= '0;
      end
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_tmo    = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign resp_err = (r_state == RESP) && r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_take) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
        r_err <= !gcd_done && w_tmo;
      end
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Round-robin scheduler sharing one GCD engine (datapath + controller pair, 16-bit operands) among NREQ requesters.
- Accepts one request at a time and sequences the engine's start/operand-load protocol: start, operand A, operand B.
- Waits for the engine's done, then returns the result to the owning requester.
- Sits between client logic and the single GCD engine instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand/result width; must match the engine data_in width.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; used only with GCD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*W  operand A, requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- req_ready  out  NREQ  one-hot, 1-cycle acceptance pulse.
- resp_valid  out  NREQ  one-hot, 1-cycle result pulse.
- resp_data  out  W  result, valid with resp_valid.
- busy  out  1  high whenever not IDLE.
- gcd_start  out  1  engine start.
- gcd_data_in  out  W  engine operand bus.
- gcd_done  in  1  engine completion.
- gcd_result  in  W  engine A-register output, sampled on gcd_done.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, resp_valid, resp_data, busy, gcd_start, gcd_data_in). rst mid-operation aborts immediately; no response issued. The engine is resynchronised by the next START.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE: if any req_valid, grant the first valid index at or after rr_ptr, searching cyclically.
  - Pulse req_ready[g].
  - Latch a_q, b_q and owner=g.
  - Set rr_ptr=(g+1) mod NREQ.
  - If a_q==0 or b_q==0: go to RESP with result = a_q|b_q (gcd(0,0)=0), bypassing the engine.
  - Otherwise go to START.
- START: gcd_start=1, gcd_data_in=a_q; next state LOAD_A.
- LOAD_A: gcd_start=0, gcd_data_in=a_q; next state LOAD_B.
- LOAD_B: gcd_data_in=b_q; next state WAIT.
- WAIT: gcd_data_in holds b_q. On gcd_done=1, capture gcd_result and go to RESP. gcd_done seen in any other state is ignored.
- RESP: resp_valid[owner]=1 and resp_data=result for exactly one cycle; then IDLE.
  - resp_data holds its value until the next RESP.
- Minimum cycles, accept to resp_valid:
  - Engine path: 4 + engine compute cycles.
  - Zero-bypass path: 1.
- Requesters hold req_valid and operands until req_ready. Dropping req_valid before grant is legal (no request is issued).
- Simultaneous requests: rr_ptr guarantees each valid requester is served within NREQ grants.
- No new grant while busy. req_ready is never asserted outside IDLE.
- Equal operands are passed to the engine normally.

Optional Feature:
- GCD_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT. At TIMEOUT_CYCLES without gcd_done, go to RESP with resp_data=0.
  - An extra output port resp_err (1 bit) is added, high with that resp_valid only.
  - The counter clears on entry to START.
- Undefined: no counter and no resp_err port; WAIT is unbounded.

Decomposition:
- Package gcd_pkg:
  - state enum (IDLE..RESP, 3-bit encoding).
  - GCD_W=16.
  - default NREQ.
  - TIMEOUT_CYCLES default.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the req vector and rr_ptr; outputs are a one-hot grant and its index. Reused by future shared-resource arbiters.
- Everything else stays in gcd_arbiter.

Test Plan:
- Single req0 (90,81), behavioural engine:
  - START cycle shows gcd_data_in=90.
  - LOAD_A shows 90; LOAD_B shows 81.
  - resp_valid[0] fires with resp_data=9.
- req1 (48,18) and req2 (35,14) raised in the same cycle, rr_ptr=0:
  - req1 granted first (resp 6), then req2 (resp 7).
  - rr_ptr ends at 3.
- req3 (0,35):
  - resp_valid[3] fires the cycle after req_ready[3], resp_data=35.
  - gcd_start never asserted.
  - (0,0) gives resp_data 0.
- rst asserted during WAIT of (270,192):
  - Next cycle all outputs are 0 and state is IDLE; no resp_valid.
  - A fresh request (270,192) then returns 6.
- GCD_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, gcd_done tied 0:
  - resp_valid and resp_err fire 16 cycles after entering WAIT, resp_data=0.
  - The next request is granted normally.
